// File: rtl/periph_router_pkg.sv
// periph_router_pkg
//   Shared types and helpers for the FT601 <-> peripheral router.
//   - router_state_t : upstream drain FSM states
//   - rr_pick        : round-robin first-set-bit search over up to 16 requesters
package periph_router_pkg;

  typedef enum logic {RTR_IDLE = 1'b0, RTR_BURST = 1'b1} router_state_t;

  localparam int RR_MAX_N = 16;

  // Returns the first index with req set, searching start, start+1, ... modulo n.
  // start must be < n; bits of req at or above n are ignored.
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  start,
                                         input int          n);
    logic [3:0] idx;
    logic       found;
    logic       hit;
    logic [4:0] cand;
    idx   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      cand  = {1'b0, start} + 5'(i);
      cand  = (cand >= 5'(n)) ? cand - 5'(n) : cand;
      hit   = (i < n) & req[cand[3:0]] & ~found;
      idx   = hit ? cand[3:0] : idx;
      found = found | hit;
    end
    return idx;
  endfunction

endpackage

// File: rtl/periph_router_rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin picker: first requester at or after start,
//   wrapping modulo NUM_PERIPH.
//   Ports:
//     req   in  NUM_PERIPH  request vector
//     start in  ADDR_W      first index to consider (< NUM_PERIPH)
//     idx   out ADDR_W      chosen index (don't care when found=0)
//     found out 1           any request present
module rr_priority_picker
  import periph_router_pkg::*;
#(
  parameter int NUM_PERIPH = 8,
  parameter int ADDR_W     = $clog2(NUM_PERIPH)
) (
  input  logic [NUM_PERIPH-1:0] req,
  input  logic [ADDR_W-1:0]     start,
  output logic [ADDR_W-1:0]     idx,
  output logic                  found
);

  logic [15:0] req_ext_s;
  logic [3:0]  start_ext_s;
  logic [3:0]  idx_ext_s;

  // Zero-extend the request vector to the helper's fixed 16-bit width
  always_comb begin
    req_ext_s                 = 16'd0;
    req_ext_s[NUM_PERIPH-1:0] = req;
  end

  assign start_ext_s = 4'(start);
  assign idx_ext_s   = rr_pick(req_ext_s, start_ext_s, NUM_PERIPH);
  assign idx         = ADDR_W'(idx_ext_s);
  assign found       = |req;

endmodule

// File: rtl/periph_router.sv
// periph_router
//   Bridge between the FT601 FIFOs and NUM_PERIPH peripherals.
//   Downstream: pops ftdi_to_lycan and steers each word to the peripheral in
//   its top ADDR_W bits; out-of-range addresses are dropped with addr_err.
//   Upstream: round-robin burst arbiter (almost-full requesters first) that
//   drains peripheral RX FIFOs into a registered lycan_to_ftdi write port.
//   Optional feature macro: PERIPH_ROUTER_STATS_EN adds drop_cnt/up_words/dn_words.
//   Ports:
//     clk, rst_l                     clock, synchronous active-low reset
//     in_data/in_empty/in_rd         ftdi_to_lycan read side (FWFT)
//     periph_tx_data/_valid/_full    peripheral TX write side
//     periph_rx_data/_empty/_almost_full/_rd  peripheral RX read side
//     out_data/out_wr/out_afull      lycan_to_ftdi write side (registered)
//     grant                          current / last granted peripheral
//     addr_err                       pulse one cycle after a dropped word
module periph_router
  import periph_router_pkg::*;
#(
  parameter int NUM_PERIPH = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = $clog2(NUM_PERIPH),
  parameter int MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_empty,
  output logic                         in_rd,
  output logic [DATA_W-1:0]            periph_tx_data,
  output logic [NUM_PERIPH-1:0]        periph_tx_valid,
  input  logic [NUM_PERIPH-1:0]        periph_tx_full,
  input  logic [NUM_PERIPH*DATA_W-1:0] periph_rx_data,
  input  logic [NUM_PERIPH-1:0]        periph_rx_empty,
  input  logic [NUM_PERIPH-1:0]        periph_rx_almost_full,
  output logic [NUM_PERIPH-1:0]        periph_rx_rd,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_wr,
  input  logic                         out_afull,
  output logic [ADDR_W-1:0]            grant,
  output logic                         addr_err
`ifdef PERIPH_ROUTER_STATS_EN
  ,
  output logic [15:0]                  drop_cnt,
  output logic [31:0]                  up_words,
  output logic [31:0]                  dn_words
`endif
);

  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PERIPH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

  // ---------------- downstream (host -> peripheral) ----------------
  logic [ADDR_W-1:0]     addr_s;
  logic [NUM_PERIPH-1:0] addr_match_s;
  logic                  addr_ok_s;
  logic                  target_full_s;
  logic                  in_rd_s;
  logic                  addr_err_r;

  assign addr_s = in_data[DATA_W-1 -: ADDR_W];

  // One-hot decode of the address field; all-zero when out of range
  always_comb begin
    addr_match_s = {NUM_PERIPH{1'b0}};
    for (int i = 0; i < NUM_PERIPH; i++) begin
      addr_match_s[i] = (addr_s == ADDR_W'(i));
    end
  end

  assign addr_ok_s     = |addr_match_s;
  assign target_full_s = |(addr_match_s & periph_tx_full);
  // Out-of-range words are always popped so they never block the stream
  assign in_rd_s         = rst_l & ~in_empty & (~addr_ok_s | ~target_full_s);
  assign in_rd           = in_rd_s;
  assign periph_tx_data  = in_data;
  assign periph_tx_valid = in_rd_s ? addr_match_s : {NUM_PERIPH{1'b0}};

  // ---------------- upstream (peripheral -> host) ----------------
  router_state_t         state_r, state_nxt_s;
  logic [ADDR_W-1:0]     grant_r, grant_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [NUM_PERIPH-1:0] req_s, af_req_s;
  logic [ADDR_W-1:0]     start_s, af_idx_s, any_idx_s;
  logic                  af_found_s, any_found_s;
  logic [NUM_PERIPH-1:0] gnt_match_s;
  logic [DATA_W-1:0]     gnt_data_s;
  logic                  gnt_empty_s;
  logic                  rd_go_s;
  logic [DATA_W-1:0]     out_data_r;
  logic                  out_wr_r;

  assign req_s    = ~periph_rx_empty;
  assign af_req_s = req_s & periph_rx_almost_full;
  // Search starts just after the last grant so it is considered last
  assign start_s  = (grant_r == LAST_IDX) ? {ADDR_W{1'b0}} : grant_r + ADDR_W'(1);

  rr_priority_picker #(.NUM_PERIPH(NUM_PERIPH), .ADDR_W(ADDR_W)) u_pick_af (
    .req   (af_req_s),
    .start (start_s),
    .idx   (af_idx_s),
    .found (af_found_s)
  );

  rr_priority_picker #(.NUM_PERIPH(NUM_PERIPH), .ADDR_W(ADDR_W)) u_pick_any (
    .req   (req_s),
    .start (start_s),
    .idx   (any_idx_s),
    .found (any_found_s)
  );

  // One-hot decode of the current grant
  always_comb begin
    gnt_match_s = {NUM_PERIPH{1'b0}};
    for (int i = 0; i < NUM_PERIPH; i++) begin
      gnt_match_s[i] = (grant_r == ADDR_W'(i));
    end
  end

  // Select data and empty flag of the granted RX FIFO
  always_comb begin
    gnt_data_s  = {DATA_W{1'b0}};
    gnt_empty_s = 1'b0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      gnt_data_s  = gnt_match_s[i] ? periph_rx_data[i*DATA_W +: DATA_W] : gnt_data_s;
      gnt_empty_s = gnt_empty_s | (gnt_match_s[i] & periph_rx_empty[i]);
    end
  end

  // out_afull only holds off reads; the burst stays open
  assign rd_go_s      = rst_l & (state_r == RTR_BURST) & ~gnt_empty_s & ~out_afull;
  assign periph_rx_rd = rd_go_s ? gnt_match_s : {NUM_PERIPH{1'b0}};

  // Upstream FSM next-state: pick in IDLE, count reads in BURST
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      RTR_IDLE: begin
        if (any_found_s) begin
          grant_nxt_s = af_found_s ? af_idx_s : any_idx_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = RTR_BURST;
        end else begin
          state_nxt_s = RTR_IDLE;
        end
      end
      RTR_BURST: begin
        if (rd_go_s) begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          state_nxt_s = (cnt_r == LAST_CNT) ? RTR_IDLE : RTR_BURST;
        end else if (gnt_empty_s) begin
          state_nxt_s = RTR_IDLE;
        end else begin
          state_nxt_s = RTR_BURST;
        end
      end
      default: begin
        state_nxt_s = RTR_IDLE;
      end
    endcase
  end

  // State, grant, burst count, output register and error pulse
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_r    <= RTR_IDLE;
      grant_r    <= LAST_IDX;
      cnt_r      <= {CNT_W{1'b0}};
      out_data_r <= {DATA_W{1'b0}};
      out_wr_r   <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      cnt_r      <= cnt_nxt_s;
      out_data_r <= rd_go_s ? gnt_data_s : out_data_r;
      out_wr_r   <= rd_go_s;
      addr_err_r <= in_rd_s & ~addr_ok_s;
    end
  end

  assign out_data = out_data_r;
  assign out_wr   = out_wr_r;
  assign grant    = grant_r;
  assign addr_err = addr_err_r;

`ifdef PERIPH_ROUTER_STATS_EN
  logic [15:0] drop_cnt_r;
  logic [31:0] up_words_r;
  logic [31:0] dn_words_r;

  // Saturating traffic counters, updated in step with the events they count
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      drop_cnt_r <= 16'd0;
      up_words_r <= 32'd0;
      dn_words_r <= 32'd0;
    end else begin
      drop_cnt_r <= ((in_rd_s & ~addr_ok_s) && (drop_cnt_r != 16'hFFFF)) ? drop_cnt_r + 16'd1 : drop_cnt_r;
      up_words_r <= (rd_go_s && (up_words_r != 32'hFFFF_FFFF)) ? up_words_r + 32'd1 : up_words_r;
      dn_words_r <= ((|periph_tx_valid) && (dn_words_r != 32'hFFFF_FFFF)) ? dn_words_r + 32'd1 : dn_words_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign up_words = up_words_r;
  assign dn_words = dn_words_r;
`endif

endmodule

// File: tb/tb_periph_router.sv
module tb_periph_router;
  localparam int NP = 6;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_l;
  logic [DW-1:0]     in_data;
  logic              in_empty;
  logic              in_rd;
  logic [DW-1:0]     periph_tx_data;
  logic [NP-1:0]     periph_tx_valid;
  logic [NP-1:0]     periph_tx_full;
  logic [NP*DW-1:0]  periph_rx_data;
  logic [NP-1:0]     periph_rx_empty;
  logic [NP-1:0]     periph_rx_almost_full;
  logic [NP-1:0]     periph_rx_rd;
  logic [DW-1:0]     out_data;
  logic              out_wr;
  logic              out_afull;
  logic [AW-1:0]     grant;
  logic              addr_err;
`ifdef PERIPH_ROUTER_STATS_EN
  logic [15:0]       drop_cnt;
  logic [31:0]       up_words;
  logic [31:0]       dn_words;
`endif

  periph_router #(.NUM_PERIPH(NP), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .in_data               (in_data),
    .in_empty              (in_empty),
    .in_rd                 (in_rd),
    .periph_tx_data        (periph_tx_data),
    .periph_tx_valid       (periph_tx_valid),
    .periph_tx_full        (periph_tx_full),
    .periph_rx_data        (periph_rx_data),
    .periph_rx_empty       (periph_rx_empty),
    .periph_rx_almost_full (periph_rx_almost_full),
    .periph_rx_rd          (periph_rx_rd),
    .out_data              (out_data),
    .out_wr                (out_wr),
    .out_afull             (out_afull),
    .grant                 (grant),
    .addr_err              (addr_err)
`ifdef PERIPH_ROUTER_STATS_EN
    ,
    .drop_cnt              (drop_cnt),
    .up_words              (up_words),
    .dn_words              (dn_words)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Peripheral RX FIFOs, owned by the bench
  logic [31:0] rxq [NP][$];
  logic [31:0] seen [$];

  // Reference model state (transaction level)
  bit          m_busy;
  int          m_grant;
  int          m_words;
  int          m_drops;
  logic [31:0] e_out_data;
  bit          e_out_wr;
  bit          e_err;
  logic          p_in_rd;
  logic [NP-1:0] p_valid;
  logic [NP-1:0] p_rx_rd;
  // Negedge samples of combinational outputs
  logic          s_in_rd;
  logic [NP-1:0] s_valid;
  logic [NP-1:0] s_rx_rd;

  typedef struct {
    logic [31:0]   data;
    logic          empty;
    logic [NP-1:0] full;
    logic          rd;
    logic [NP-1:0] valid;
    logic          err;
  } vec_t;
  vec_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag(input int p, input int k);
    return {4'h0, 4'(p), 24'(k)};
  endfunction

  task automatic drive_rx();
    for (int i = 0; i < NP; i++) begin
      periph_rx_empty[i]          = (rxq[i].size() == 0);
      periph_rx_data[i*DW +: DW]  = (rxq[i].size() == 0) ? 32'h0 : rxq[i][0];
    end
  endtask

  function automatic void predict();
    int a;
    a = int'(in_data[31:29]);
    p_in_rd = rst_l && !in_empty && ((a >= NP) || !periph_tx_full[a]);
    p_valid = (p_in_rd && a < NP) ? NP'(1 << a) : '0;
    p_rx_rd = '0;
    if (rst_l && m_busy && rxq[m_grant].size() > 0 && !out_afull) p_rx_rd[m_grant] = 1'b1;
  endfunction

  function automatic void pick();
    int best;
    best = -1;
    for (int k = 1; k <= NP; k++) begin
      int c;
      c = (m_grant + k) % NP;
      if (best < 0 && rxq[c].size() > 0 && periph_rx_almost_full[c]) best = c;
    end
    for (int k = 1; k <= NP; k++) begin
      int c;
      c = (m_grant + k) % NP;
      if (best < 0 && rxq[c].size() > 0) best = c;
    end
    if (best >= 0) begin
      m_grant = best;
      m_busy  = 1'b1;
      m_words = 0;
    end
  endfunction

  function automatic void update();
    int a;
    a = int'(in_data[31:29]);
    if (!rst_l) begin
      m_busy = 1'b0; m_grant = NP - 1; m_words = 0; m_drops = 0;
      e_out_wr = 1'b0; e_out_data = 32'h0; e_err = 1'b0;
      return;
    end
    e_err = p_in_rd && (a >= NP);
    if (e_err) m_drops++;
    e_out_wr = 1'b0;
    if (m_busy) begin
      if (p_rx_rd != '0) begin
        e_out_data = rxq[m_grant].pop_front();
        e_out_wr   = 1'b1;
        m_words++;
        if (m_words == MB) m_busy = 1'b0;
      end else if (rxq[m_grant].size() == 0) begin
        m_busy = 1'b0;
      end
    end else begin
      pick();
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    predict();
    s_in_rd = in_rd; s_valid = periph_tx_valid; s_rx_rd = periph_rx_rd;
    chk("in_rd", 32'(in_rd), 32'(p_in_rd));
    chk("tx_valid", 32'(periph_tx_valid), 32'(p_valid));
    chk("tx_data", periph_tx_data, in_data);
    chk("rx_rd", 32'(periph_rx_rd), 32'(p_rx_rd));
    @(posedge clk);
    update();
    #1;
    drive_rx();
    if (out_wr === 1'b1) seen.push_back(out_data);
    chk("out_wr", 32'(out_wr), 32'(e_out_wr));
    chk("out_data", out_data, e_out_data);
    chk("grant", 32'(grant), 32'(m_grant));
    chk("addr_err", 32'(addr_err), 32'(e_err));
  endtask

  task automatic do_reset();
    rst_l = 1'b0; in_empty = 1'b1; out_afull = 1'b0;
    periph_tx_full = '0; periph_rx_almost_full = '0;
    for (int i = 0; i < NP; i++) rxq[i].delete();
    drive_rx();
    tick();
    tick();
    rst_l = 1'b1;
    seen.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    for (int t = 0; t < budget && seen.size() < n; t++) tick();
    chk(name, 32'(seen.size()), 32'(n));
  endtask

  initial begin
    int deliveries;
    int mark;
    int first_other;
    int n;
    logic [31:0] expq [$];
    int order [6] = '{0, 3, 0, 3, 0, 3};
    int base  [6] = '{0, 0, 4, 4, 8, 8};
    int len   [6] = '{4, 4, 4, 4, 2, 2};

    vec[0] = '{32'h2000_00AA, 1'b0, 6'h00, 1'b1, 6'h02, 1'b0};
    vec[1] = '{32'h2000_00AA, 1'b0, 6'h02, 1'b0, 6'h00, 1'b0};
    vec[2] = '{32'hE000_0001, 1'b0, 6'h00, 1'b1, 6'h00, 1'b1};
    vec[3] = '{32'hC000_0005, 1'b0, 6'h3F, 1'b1, 6'h00, 1'b1};
    vec[4] = '{32'hA000_0000, 1'b0, 6'h1F, 1'b1, 6'h20, 1'b0};
    vec[5] = '{32'hA000_0000, 1'b0, 6'h20, 1'b0, 6'h00, 1'b0};
    vec[6] = '{32'h0000_1234, 1'b1, 6'h00, 1'b0, 6'h00, 1'b0};
    vec[7] = '{32'hE000_0001, 1'b1, 6'h00, 1'b0, 6'h00, 1'b0};
    vec[8] = '{32'h8000_0000, 1'b0, 6'h00, 1'b1, 6'h10, 1'b0};
    vec[9] = '{32'h0000_0000, 1'b0, 6'h3E, 1'b1, 6'h01, 1'b0};

    rst_l = 1'b0; in_data = 32'h0; in_empty = 1'b1; out_afull = 1'b0;
    periph_tx_full = '0; periph_rx_almost_full = '0; periph_rx_data = '0;
    m_busy = 1'b0; m_grant = NP - 1; m_words = 0; m_drops = 0;
    e_out_wr = 1'b0; e_out_data = 32'h0; e_err = 1'b0;
    drive_rx();
    do_reset();
    chk("rst_grant", 32'(grant), 32'd5);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);

    // Downstream vector table
    for (int i = 0; i < 10; i++) begin
      in_data = vec[i].data; in_empty = vec[i].empty; periph_tx_full = vec[i].full;
      tick();
      chk("vec_in_rd", 32'(s_in_rd), 32'(vec[i].rd));
      chk("vec_valid", 32'(s_valid), 32'(vec[i].valid));
      chk("vec_addr_err", 32'(addr_err), 32'(vec[i].err));
    end
`ifdef PERIPH_ROUTER_STATS_EN
    chk("drop_cnt_vec", 32'(drop_cnt), 32'd2);
`endif

    // Full target stalls the head word, then it is delivered once
    in_data = 32'h2000_00AA; in_empty = 1'b0; periph_tx_full = 6'h02; deliveries = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_rd", 32'(s_in_rd), 32'd0);
      deliveries += int'(s_valid[1]);
    end
    periph_tx_full = 6'h00;
    tick();
    chk("release_in_rd", 32'(s_in_rd), 32'd1);
    deliveries += int'(s_valid[1]);
    in_empty = 1'b1;
    tick();
    chk("deliver_once", 32'(deliveries), 32'd1);

    // Two requesters with 10 words each: alternating bursts 4,4,4,4,2,2
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rxq[0].push_back(tag(0, k));
      rxq[3].push_back(tag(3, k));
    end
    drive_rx();
    run_until(20, 300, "rr_count");
    expq.delete();
    for (int b = 0; b < 6; b++)
      for (int w = 0; w < len[b]; w++) expq.push_back(tag(order[b], base[b] + w));
    n = (seen.size() < 20) ? seen.size() : 20;
    for (int i = 0; i < n; i++) chk("rr_order", seen[i], expq[i]);

    // Granted FIFO runs dry mid-burst: grant moves on
    do_reset();
    for (int k = 0; k < 2; k++) rxq[2].push_back(tag(2, k));
    for (int k = 0; k < 3; k++) rxq[4].push_back(tag(4, k));
    drive_rx();
    run_until(5, 100, "dry_count");
    expq.delete();
    expq.push_back(tag(2, 0)); expq.push_back(tag(2, 1));
    expq.push_back(tag(4, 0)); expq.push_back(tag(4, 1)); expq.push_back(tag(4, 2));
    n = (seen.size() < 5) ? seen.size() : 5;
    for (int i = 0; i < n; i++) chk("dry_order", seen[i], expq[i]);
    chk("dry_grant", 32'(grant), 32'd4);

    // Almost-full requester pre-empts waiting normal requesters
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rxq[0].push_back(tag(0, k));
      rxq[1].push_back(tag(1, k));
    end
    drive_rx();
    tick();
    tick();
    mark = seen.size();
    for (int k = 0; k < 4; k++) rxq[5].push_back(tag(5, k));
    periph_rx_almost_full = 6'h20;
    drive_rx();
    for (int t = 0; t < 40 && rxq[5].size() != 0; t++) tick();
    tick();
    first_other = -1;
    for (int i = mark; i < seen.size(); i++)
      if (first_other < 0 && seen[i][27:24] != 4'd0) first_other = int'(seen[i][27:24]);
    chk("af_preempt", 32'(first_other), 32'd5);
    periph_rx_almost_full = '0;
    for (int t = 0; t < 100 && (rxq[0].size() != 0 || rxq[1].size() != 0); t++) tick();

    // out_afull stalls a burst without loss or duplication
    do_reset();
    for (int k = 0; k < 8; k++) rxq[1].push_back(tag(1, k));
    drive_rx();
    tick(); tick(); tick();
    out_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("afull_rx_rd", 32'(s_rx_rd), 32'd0);
    end
    out_afull = 1'b0;
    run_until(8, 100, "afull_count");
    n = (seen.size() < 8) ? seen.size() : 8;
    for (int i = 0; i < n; i++) chk("afull_order", seen[i], tag(1, i));

    // Reset in the middle of a burst
    for (int k = 0; k < 4; k++) rxq[2].push_back(tag(2, k));
    drive_rx();
    tick(); tick();
    rst_l = 1'b0;
    tick();
    chk("midrst_rx_rd", 32'(s_rx_rd), 32'd0);
    chk("midrst_out_wr", 32'(out_wr), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd5);
    rst_l = 1'b1;

    // Randomized traffic on both paths against the model
    for (int t = 0; t < 1500; t++) begin
      rst_l                 = ($urandom_range(0, 299) != 0);
      in_empty              = ($urandom_range(0, 2) == 0);
      in_data               = $urandom;
      periph_tx_full        = NP'($urandom) & NP'($urandom);
      periph_rx_almost_full = NP'($urandom) & NP'($urandom) & NP'($urandom);
      out_afull             = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        if (rxq[p].size() < 12) rxq[p].push_back($urandom);
      end
      drive_rx();
      tick();
    end
`ifdef PERIPH_ROUTER_STATS_EN
    chk("drop_cnt_rand", 32'(drop_cnt), 32'(m_drops));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
